// File: rtl/pronoc_pkg.sv
// Shared types and helpers for the ProNoC endpoint injection logic.
package pronoc_pkg;

  typedef enum logic {SCH_IDLE, SCH_LOCKED} inj_sch_state_t;

  // Width of a counter that must hold every value from 0 to b.
  function automatic int crd_w(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/ep_rr_arbiter.sv
// Stateless round-robin arbiter: the first request at or after ptr wins.
module ep_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr) + i) % N;
        if (!found && request[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Shares one NoC injection port among NR requesters with packet-granular
// round-robin arbitration and per-VC downstream credit tracking.
module noc_inject_scheduler
  import pronoc_pkg::*;
#(
  parameter int NR = 4,
  parameter int V  = 2,
  parameter int B  = 4,
  parameter int Fw = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NR*Fw-1:0]  req_flit,
  input  logic [NR-1:0]     req_valid,
  input  logic [NR-1:0]     req_hdr,
  input  logic [NR-1:0]     req_tail,
  input  logic [NR*V-1:0]   req_vc,
  output logic [NR-1:0]     req_ready,
  output logic [Fw-1:0]     flit_out,
  output logic              flit_out_wr,
  input  logic [V-1:0]      credit_in
);

  localparam int CW = crd_w(B);
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [CW-1:0] B_CNT = CW'(B);

  inj_sch_state_t state, state_next;
  logic [IW-1:0]  rr_ptr, owner, grant_idx, acc_idx;
  logic [V-1:0]   lock_vc, owner_vc, vc_has_credit, send_vc;
  logic [CW-1:0]  credit_cnt [V];
  logic [NR-1:0]  eligible, grant;
  logic           owner_ok, accept;

  always_comb begin
    for (int v = 0; v < V; v++) vc_has_credit[v] = (credit_cnt[v] != '0);
  end

  // Only headers whose target VC has buffer space may compete in IDLE.
  always_comb begin
    for (int r = 0; r < NR; r++)
      eligible[r] = req_valid[r] & req_hdr[r] & |(req_vc[r*V +: V] & vc_has_credit);
  end

  ep_rr_arbiter #(.N(NR), .IW(IW)) u_arb (
    .request   (eligible),
    .ptr       (rr_ptr),
    .enable    ((state == SCH_IDLE) && !reset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A malformed owner flit (wrong VC or a new header) is refused, not forwarded.
  always_comb begin
    owner_vc = req_vc[int'(owner)*V +: V];
    owner_ok = req_valid[owner] & |(lock_vc & vc_has_credit) &
               (owner_vc == lock_vc) & ~req_hdr[owner];
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    acc_idx    = grant_idx;
    if (!reset) begin
      case (state)
        SCH_IDLE: begin
          req_ready = grant;
          if (|grant && !req_tail[grant_idx]) state_next = SCH_LOCKED;
        end
        SCH_LOCKED: begin
          acc_idx = owner;
          if (owner_ok) begin
            req_ready[owner] = 1'b1;
            if (req_tail[owner]) state_next = SCH_IDLE;
          end
        end
        default: state_next = SCH_IDLE;
      endcase
    end
  end

  always_comb begin
    accept  = |req_ready;
    send_vc = accept ? req_vc[int'(acc_idx)*V +: V] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SCH_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      owner   <= '0;
      lock_vc <= '0;
    end else if (state == SCH_IDLE && accept) begin
      rr_ptr  <= (grant_idx == IW'(NR - 1)) ? '0 : grant_idx + IW'(1);
      owner   <= grant_idx;
      lock_vc <= req_vc[int'(grant_idx)*V +: V];
    end
  end

  // Simultaneous send and return cancel out; an excess return saturates at B.
  always_ff @(posedge clk) begin
    for (int v = 0; v < V; v++) begin
      if (reset) credit_cnt[v] <= B_CNT;
      else begin
        case ({send_vc[v], credit_in[v]})
          2'b10:   credit_cnt[v] <= credit_cnt[v] - CW'(1);
          2'b01:   if (credit_cnt[v] != B_CNT) credit_cnt[v] <= credit_cnt[v] + CW'(1);
          default: credit_cnt[v] <= credit_cnt[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= accept;
      if (accept) flit_out <= req_flit[int'(acc_idx)*Fw +: Fw];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NR; r++)
        if (req_valid[r]) assert ($onehot(req_vc[r*V +: V]));
      for (int v = 0; v < V; v++)
        if (credit_in[v] && !send_vc[v]) assert (credit_cnt[v] != B_CNT);
      if (state == SCH_LOCKED && req_valid[owner])
        assert (!req_hdr[owner] && owner_vc == lock_vc);
    end
  end

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Randomized packet traffic against a packet-level reference model of the
// injection scheduler, with directed phases for credit starvation and reset.
module tb_noc_inject_scheduler;

  localparam int NR = 4;
  localparam int V  = 2;
  localparam int B  = 4;
  localparam int FW = 36;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*FW-1:0]  req_flit;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_hdr;
  logic [NR-1:0]     req_tail;
  logic [NR*V-1:0]   req_vc;
  logic [NR-1:0]     req_ready;
  logic [FW-1:0]     flit_out;
  logic              flit_out_wr;
  logic [V-1:0]      credit_in;

  noc_inject_scheduler #(.NR(NR), .V(V), .B(B), .Fw(FW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_flit    (req_flit),
    .req_valid   (req_valid),
    .req_hdr     (req_hdr),
    .req_tail    (req_tail),
    .req_vc      (req_vc),
    .req_ready   (req_ready),
    .flit_out    (flit_out),
    .flit_out_wr (flit_out_wr),
    .credit_in   (credit_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester sources: each walks through randomly sized packets.
  int          p_len [NR];
  int          p_pos [NR];
  int          p_vc  [NR];
  logic [FW-1:0] cur_data [NR];
  int          valid_pct;
  int          cr_pct;

  // Reference model: lock owner (-1 when free), credits, next search start.
  int          m_owner;
  int          m_cred [V];
  int          m_rr;
  logic        m_wr;
  logic [FW-1:0] m_flit;

  function automatic logic [FW-1:0] randFlit();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[FW-1:0];
  endfunction

  task automatic newPacket(input int r);
    p_len[r]    = $urandom_range(1, 4);
    p_pos[r]    = 0;
    p_vc[r]     = $urandom_range(0, V - 1);
    cur_data[r] = randFlit();
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_rr    = 0;
    m_wr    = 1'b0;
    m_flit  = '0;
    for (int v = 0; v < V; v++) m_cred[v] = B;
    for (int r = 0; r < NR; r++) newPacket(r);
  endtask

  task automatic applyStimulus();
    logic [V-1:0] onehot;
    for (int r = 0; r < NR; r++) begin
      onehot = '0;
      onehot[p_vc[r]] = 1'b1;
      req_valid[r]          = (int'($urandom_range(0, 99)) < valid_pct);
      req_hdr[r]            = (p_pos[r] == 0);
      req_tail[r]           = (p_pos[r] == p_len[r] - 1);
      req_vc[r*V +: V]      = onehot;
      req_flit[r*FW +: FW]  = cur_data[r];
    end
    for (int v = 0; v < V; v++)
      credit_in[v] = (m_cred[v] < B) && (int'($urandom_range(0, 99)) < cr_pct);
  endtask

  function automatic logic [NR-1:0] computeReady();
    logic [NR-1:0] er;
    int r;
    er = '0;
    if (reset) return er;
    if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        r = (m_rr + k) % NR;
        if (req_valid[r] && p_pos[r] == 0 && m_cred[p_vc[r]] > 0) begin
          er[r] = 1'b1;
          break;
        end
      end
    end else if (req_valid[m_owner] && m_cred[p_vc[m_owner]] > 0) begin
      er[m_owner] = 1'b1;
    end
    return er;
  endfunction

  task automatic checkOutput(input logic [NR-1:0] er);
    n_vec++;
    assert (req_ready === er) else begin
      n_err++;
      $error("[TB] FAIL req_ready: observed %b expected %b", req_ready, er);
    end
    n_vec++;
    assert (flit_out_wr === m_wr) else begin
      n_err++;
      $error("[TB] FAIL flit_out_wr: observed %b expected %b", flit_out_wr, m_wr);
    end
    n_vec++;
    assert (flit_out === m_flit) else begin
      n_err++;
      $error("[TB] FAIL flit_out: observed %h expected %h", flit_out, m_flit);
    end
  endtask

  task automatic modelUpdate(input logic [NR-1:0] er);
    int sent [V];
    if (reset) begin
      modelReset();
      return;
    end
    for (int v = 0; v < V; v++) sent[v] = 0;
    m_wr = |er;
    for (int r = 0; r < NR; r++) begin
      if (er[r]) begin
        m_flit = cur_data[r];
        sent[p_vc[r]] = 1;
        if (m_owner < 0) begin
          m_rr = (r + 1) % NR;
          if (p_len[r] > 1) m_owner = r;
        end
        if (p_pos[r] == p_len[r] - 1) begin
          m_owner = -1;
          newPacket(r);
        end else begin
          p_pos[r]++;
          cur_data[r] = randFlit();
        end
      end
    end
    for (int v = 0; v < V; v++) m_cred[v] = m_cred[v] + int'(credit_in[v]) - sent[v];
  endtask

  task automatic runCycle();
    logic [NR-1:0] er;
    applyStimulus();
    @(negedge clk);
    er = computeReady();
    checkOutput(er);
    modelUpdate(er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    reset     = 1'b1;
    valid_pct = 70;
    cr_pct    = 50;
    modelReset();
    applyStimulus();
    @(posedge clk);
    #1;
    repeat (3) runCycle();
    reset = 1'b0;

    $display("[TB] random mixed traffic");
    cr_pct = 60;
    repeat (300) runCycle();

    $display("[TB] credit starvation, then single returns");
    valid_pct = 100;
    cr_pct    = 0;
    repeat (20) runCycle();
    cr_pct = 100;
    runCycle();
    cr_pct = 0;
    repeat (6) runCycle();

    $display("[TB] full-rate streaming with credits returned every cycle");
    cr_pct = 100;
    repeat (100) runCycle();

    $display("[TB] reset while a packet is locked");
    valid_pct = 80;
    cr_pct    = 50;
    waited    = 0;
    while (m_owner < 0 && waited < 200) begin
      runCycle();
      waited++;
    end
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    repeat (300) runCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
